// File: rtl/pmbus_target_responder.sv
// Oversampled PMBus/I2C target with a 16-byte register bank.
// Answers byte/word/block writes and pointer-then-read transfers with repeated start.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | SDA released, waiting for START
// ADDR      | shifting in the 8-bit address byte
// ACK       | driving ACK: low on first SCL fall, release on second
// CMD       | shifting in the command byte (low nibble becomes ptr)
// WDATA     | shifting in a data byte, written to bank[ptr]
// RDATA     | driving tx byte MSB first, one bit per SCL fall
// RACK      | sampling master ACK/NACK after a read byte
// IDLE_WAIT | master NACKed a read, waiting for STOP or START
`timescale 1ns/1ps
module pmbus_target_responder #(
    parameter logic [6:0]   TARGET_ADDR = 7'h24,
    parameter logic [127:0] BANK_INIT   = 128'h0
) (
    input  logic       I_CLK_4M,
    input  logic       I_rst_n,
    input  logic       I_SCL,
    input  logic       I_SDA,
    output logic       O_SDA_oe,
    output logic       O_wr_pulse,
    output logic [7:0] O_wr_cmd,
    output logic [7:0] O_wr_data,
    output logic       O_stop_pulse,
    output logic       O_busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_IDLE_WAIT
    } state_t;

    state_t      state;
    state_t      ack_next;
    logic        ack_drv;
    logic [2:0]  scl_q;
    logic [2:0]  sda_q;
    logic [3:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [7:0]  tx;
    logic [3:0]  ptr;
    logic [7:0]  bank [16];

    logic        sda_bit;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_evt;
    logic        stop_evt;
    logic [7:0]  rx_byte;

    // index 1 is the synchronized level, index 2 the previous one for edges
    assign sda_bit   = sda_q[1];
    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_evt =  scl_q[1] &  sda_q[2] & ~sda_q[1];
    assign stop_evt  =  scl_q[1] & ~sda_q[2] &  sda_q[1];
    assign rx_byte   = {shreg, sda_bit};

    always_ff @(posedge I_CLK_4M) begin
        if (!I_rst_n) begin
            scl_q        <= 3'b111;
            sda_q        <= 3'b111;
            state        <= ST_IDLE;
            ack_next     <= ST_IDLE;
            ack_drv      <= 1'b0;
            bit_cnt      <= 4'd0;
            shreg        <= 7'd0;
            tx           <= 8'd0;
            ptr          <= 4'd0;
            O_SDA_oe     <= 1'b0;
            O_wr_pulse   <= 1'b0;
            O_wr_cmd     <= 8'd0;
            O_wr_data    <= 8'd0;
            O_stop_pulse <= 1'b0;
            O_busy       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                bank[i] <= BANK_INIT[8*i +: 8];
            end
        end else begin
            scl_q        <= {scl_q[1:0], I_SCL};
            sda_q        <= {sda_q[1:0], I_SDA};
            O_wr_pulse   <= 1'b0;
            O_stop_pulse <= 1'b0;

            if (start_evt) begin
                state    <= ST_ADDR;
                bit_cnt  <= 4'd0;
                O_SDA_oe <= 1'b0;
                O_busy   <= 1'b0;
            end else if (stop_evt) begin
                state        <= ST_IDLE;
                O_SDA_oe     <= 1'b0;
                O_stop_pulse <= O_busy;
                O_busy       <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state    <= ST_ACK;
                                    ack_drv  <= 1'b0;
                                    O_busy   <= 1'b1;
                                    ack_next <= rx_byte[0] ? ST_RDATA : ST_CMD;
                                    tx       <= bank[ptr];
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end

                    ST_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                O_SDA_oe <= 1'b1;
                                ack_drv  <= 1'b1;
                            end else begin
                                bit_cnt  <= 4'd0;
                                state    <= ack_next;
                                O_SDA_oe <= (ack_next == ST_RDATA) ? ~tx[7] : 1'b0;
                            end
                        end
                    end

                    ST_CMD: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                ptr      <= rx_byte[3:0];
                                state    <= ST_ACK;
                                ack_drv  <= 1'b0;
                                ack_next <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bank[ptr]  <= rx_byte;
                                O_wr_pulse <= 1'b1;
                                O_wr_cmd   <= {4'h0, ptr};
                                O_wr_data  <= rx_byte;
                                ptr        <= ptr + 4'd1;
                                state      <= ST_ACK;
                                ack_drv    <= 1'b0;
                                ack_next   <= ST_WDATA;
                            end
                        end
                    end

                    // bit_cnt counts rising edges; the MSB is already on the bus at entry
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                O_SDA_oe <= 1'b0;
                                state    <= ST_RACK;
                            end else begin
                                O_SDA_oe <= ~tx[3'd7 - bit_cnt[2:0]];
                            end
                        end
                    end

                    ST_RACK: begin
                        if (scl_rise) begin
                            if (!sda_bit) begin
                                ptr     <= ptr + 4'd1;
                                tx      <= bank[ptr + 4'd1];
                                bit_cnt <= 4'd0;
                                state   <= ST_RDATA;
                            end else begin
                                state <= ST_IDLE_WAIT;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pmbus_target_responder.sv
// Directed bench for pmbus_target_responder: bit-banged PMBus master on an
// open-drain bus, checking ACKs, read data, write strobes and STOP strobes.
`timescale 1ns/1ps
module tb_pmbus_target_responder;

    localparam int Q = 10;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       m_sda_low;
    logic       sda_pin;
    logic       sda_oe;
    logic       wr_pulse;
    logic [7:0] wr_cmd;
    logic [7:0] wr_data;
    logic       stop_pulse;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] wr_q [$];
    int          stop_cnt = 0;
    logic        oe_seen  = 1'b0;
    int          wr_idx   = 0;

    assign sda_pin = ~(sda_oe | m_sda_low);

    pmbus_target_responder #(
        .TARGET_ADDR (7'h24),
        .BANK_INIT   (128'h0)
    ) dut (
        .I_CLK_4M     (clk),
        .I_rst_n      (rst_n),
        .I_SCL        (scl),
        .I_SDA        (sda_pin),
        .O_SDA_oe     (sda_oe),
        .O_wr_pulse   (wr_pulse),
        .O_wr_cmd     (wr_cmd),
        .O_wr_data    (wr_data),
        .O_stop_pulse (stop_pulse),
        .O_busy       (busy)
    );

    initial clk = 1'b0;
    always #125 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse) wr_q.push_back({wr_cmd, wr_data});
        if (stop_pulse) stop_cnt++;
        if (sda_oe) oe_seen <= 1'b1;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation exceeded time limit, observed running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        got = (wr_q.size() > wr_idx) ? wr_q[wr_idx] : 16'hxxxx;
        wr_idx++;
        check(tag, got, exp);
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic drive_val, output logic sampled);
        m_sda_low = ~drive_val;
        wait_q();
        scl = 1'b1;
        wait_q();
        sampled = sda_pin;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~master_ack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;

        rst_n     = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_oe", sda_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_wr_cmd", wr_cmd, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // address mismatch: 0x25 write
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'h4A, ack);
        check("mismatch_ack", ack, 1'b0);
        check("mismatch_busy", busy, 1'b0);
        check("mismatch_oe_seen", oe_seen, 1'b0);
        bus_stop();
        check("mismatch_wr_cnt", wr_q.size(), 16'd0);
        check("mismatch_stop_cnt", stop_cnt, 16'd0);

        // word write: cmd 0x21, data 0x5A 0xC3
        bus_start();
        write_byte(8'h48, ack);
        check("ww_addr_ack", ack, 1'b1);
        check("ww_busy", busy, 1'b1);
        write_byte(8'h21, ack);
        check("ww_cmd_ack", ack, 1'b1);
        write_byte(8'h5A, ack);
        check("ww_d0_ack", ack, 1'b1);
        write_byte(8'hC3, ack);
        check("ww_d1_ack", ack, 1'b1);
        bus_stop();
        check_wr("ww_pulse0", 16'h015A);
        check_wr("ww_pulse1", 16'h02C3);
        check("ww_stop_cnt", stop_cnt, 16'd1);
        check("ww_busy_after", busy, 1'b0);

        // read two bytes from cmd 0x01 via repeated start
        bus_start();
        write_byte(8'h48, ack);
        check("rd_addr_ack", ack, 1'b1);
        write_byte(8'h01, ack);
        check("rd_cmd_ack", ack, 1'b1);
        bus_start();
        write_byte(8'h49, ack);
        check("rd_raddr_ack", ack, 1'b1);
        read_byte(1'b1, d);
        check("rd_byte0", d, 8'h5A);
        read_byte(1'b0, d);
        check("rd_byte1", d, 8'hC3);
        check("rd_oe_after_nack", sda_oe, 1'b0);
        check("rd_busy_before_stop", busy, 1'b1);
        bus_stop();
        check("rd_busy_after_stop", busy, 1'b0);
        check("rd_stop_cnt", stop_cnt, 16'd2);
        check("rd_wr_cnt", wr_q.size(), 16'd2);

        // pointer wrap 15 -> 0
        bus_start();
        write_byte(8'h48, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack);
        check("wrap_d0_ack", ack, 1'b1);
        write_byte(8'h22, ack);
        check("wrap_d1_ack", ack, 1'b1);
        bus_stop();
        check_wr("wrap_pulse0", 16'h0F11);
        check_wr("wrap_pulse1", 16'h0022);
        bus_start();
        write_byte(8'h48, ack);
        write_byte(8'h0F, ack);
        bus_start();
        write_byte(8'h49, ack);
        read_byte(1'b1, d);
        check("wrap_rd0", d, 8'h11);
        read_byte(1'b0, d);
        check("wrap_rd1", d, 8'h22);
        bus_stop();
        check("wrap_stop_cnt", stop_cnt, 16'd4);

        // abort after 4 data bits
        bus_start();
        write_byte(8'h48, ack);
        write_byte(8'h03, ack);
        check("abort_cmd_ack", ack, 1'b1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        bus_stop();
        check("abort_wr_cnt", wr_q.size(), 16'd4);
        check("abort_stop_cnt", stop_cnt, 16'd5);
        check("abort_oe", sda_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        bus_start();
        write_byte(8'h48, ack);
        check("abort_next_ack", ack, 1'b1);
        write_byte(8'h03, ack);
        bus_start();
        write_byte(8'h49, ack);
        read_byte(1'b0, d);
        check("abort_bank3", d, 8'h00);
        bus_stop();

        // reset while target drives a 0 bit (MSB of 0x5A)
        bus_start();
        write_byte(8'h48, ack);
        write_byte(8'h01, ack);
        bus_start();
        write_byte(8'h49, ack);
        check("rst_pre_oe", sda_oe, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        bus_stop();
        check("rst_stop_cnt", stop_cnt, 16'd6);
        bus_start();
        write_byte(8'h48, ack);
        check("rst_next_ack", ack, 1'b1);
        write_byte(8'h01, ack);
        bus_start();
        write_byte(8'h49, ack);
        check("rst_next_raddr_ack", ack, 1'b1);
        read_byte(1'b1, d);
        check("rst_bank1", d, 8'h00);
        read_byte(1'b0, d);
        check("rst_bank2", d, 8'h00);
        bus_stop();
        check("rst_final_stop_cnt", stop_cnt, 16'd7);
        check("final_wr_cnt", wr_q.size(), 16'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmbus_target_responder.md
Name: pmbus_target_responder

Overview:
- Oversampled I2C/PMBus target (slave) that answers transactions from the board-level TPS546C20A-style PMBus master.
- Contains a 16-byte command/register bank. Handles write-byte/word and block writes, plus read-byte/word with repeated start.
- Lets the existing master-side write sequencer be exercised in loopback on the same FPGA, and serves as the bench model for it.
- Runs on the 4 MHz PLL clock; SCL is at most 100 kHz, so there are at least 40 samples per SCL period.

Parameters:
- TARGET_ADDR, 7'h24, 7-bit target address answered; all other addresses are ignored.
- BANK_INIT, 128'h0, reset contents of bank; byte n = BANK_INIT[8n+7:8n].

Ports:
- I_CLK_4M  in  1  sole clock, rising edge.
- I_rst_n  in  1  synchronous active-low reset.
- I_SCL  in  1  bus SCL (asynchronous).
- I_SDA  in  1  bus SDA input (asynchronous, pad readback).
- O_SDA_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- O_wr_pulse  out  1  one-cycle strobe per data byte written into bank.
- O_wr_cmd  out  8  bank index (zero-extended) of the byte written; valid with O_wr_pulse.
- O_wr_data  out  8  byte written; valid with O_wr_pulse.
- O_stop_pulse  out  1  one-cycle strobe on STOP that ends an addressed transaction.
- O_busy  out  1  1 from address match until STOP or next START.

Behaviour:
- **Input sync:** I_SCL and I_SDA each pass through 2-flop synchronizers, then a third register for edge detection. Event latency from pin is 3 cycles.
- **START:** synced SDA falls while synced SCL is high. Accepted in any state, including repeated start; moves to ADDR with bit count 0.
- **STOP:** synced SDA rises while synced SCL is high. Accepted in any state: releases SDA and returns to IDLE. Pulses O_stop_pulse only if O_busy was 1.
- **Bit timing:**
  - Bits are sampled on the SCL rising edge event.
  - Target-driven SDA changes only on the SCL falling edge event.
  - SDA is never changed while SCL is high.
- **States:**
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits, MSB first.
    - If addr[7:1] == TARGET_ADDR: go to ADDR_ACK and set O_busy.
    - Else: go to IDLE, with no ACK and SDA untouched.
  - ADDR_ACK: drive SDA low on the falling edge after bit 8; release on the next falling edge.
    - R/W = 0: go to CMD.
    - R/W = 1: load tx byte = bank[ptr] and go to RDATA.
  - CMD: shift 8 bits; ptr <= cmd[3:0], and cmd[7:4] is ignored. ACK always, then go to WDATA.
  - WDATA: shift 8 bits; on the 8th rising edge:
    - bank[ptr] <= byte;
    - O_wr_pulse = 1 for 1 cycle, with O_wr_cmd = {4'h0, ptr} and O_wr_data = byte;
    - ptr <= ptr + 1, wrapping 15 -> 0.
    - Then ACK and loop back to WDATA.
  - RDATA: drive tx bit MSB first; O_SDA_oe = ~bit, updated on each falling edge. After 8 bits, release SDA and go to RACK.
  - RACK: sample master ACK on the 9th rising edge.
    - ACK (SDA low): ptr <= ptr + 1 (wrap); load bank[ptr+1]; drive its MSB on the falling edge; go to RDATA.
    - NACK: go to IDLE_WAIT, SDA released, waiting for STOP/START.
- **Partial transactions:**
  - A repeated start after CMD keeps ptr, which gives the write-pointer-then-read sequence.
  - A write with no data bytes (send-byte) only sets ptr.
  - A START or STOP mid-byte discards the partial byte; no bank write and no pulse occur.
- **Reset** (sync, I_rst_n low at a clock edge):
  - Takes effect even mid-transaction.
  - State = IDLE, ptr = 0, bank = BANK_INIT.
  - O_SDA_oe = 0, O_wr_pulse = 0, O_wr_cmd = 0, O_wr_data = 0, O_stop_pulse = 0, O_busy = 0.
  - Synchronizer flops reset to 1, the idle bus level, so no false START is seen.
- **Simultaneous events:** a START/STOP event takes priority over a SCL edge event in the same cycle.

Test Plan:
- **Address mismatch:** reset, then write to addr 7'h25 -> O_SDA_oe stays 0 for all 9 clocks, O_busy = 0, no O_wr_pulse, no O_stop_pulse.
- **Word write:** write to 0x24 with cmd 0x21 and data 0x5A, 0xC3, then STOP.
  - ACK on all 4 bytes.
  - O_wr_pulse with cmd 0x01/data 0x5A, then cmd 0x02/data 0xC3.
  - O_stop_pulse once; bank[1] = 0x5A and bank[2] = 0xC3.
- **Read with repeated start:** after the word write, do S 0x48 cmd 0x01, Sr 0x49, read 2 bytes with ACK then NACK, then P.
  - SDA carries 0x5A then 0xC3.
  - SDA is released after the NACK; O_busy falls at STOP.
- **Pointer wrap:** write cmd 0x0F with data 0x11, 0x22 -> O_wr_cmd 0x0F then 0x00; reading back from cmd 0x0F returns 0x11, 0x22.
- **Abort mid-byte:** STOP after 4 data bits of a write -> no O_wr_pulse, bank unchanged, SDA released, state IDLE.
- **Reset mid-read:** assert I_rst_n low for 1 cycle while driving a 0 bit -> O_SDA_oe = 0 the next cycle; the next transaction works normally and bank = BANK_INIT.
